// File: rtl/redmule_tcdm_responder.sv
`default_nettype none
// ============================================================================
//  Module   : redmule_tcdm_responder
//  Brief    : TCDM responder with fixed read latency and credit-bounded
//             response FIFO, backed by a local word-addressed memory.
//  Revision : 1.0
// ============================================================================
module redmule_tcdm_responder #(
   parameter int DW         = 288,
   parameter int AW         = 32,
   parameter int UW         = 1,
   parameter int DEPTH      = 256,
   parameter int LAT        = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            clear_i,
   input  logic                            stall_i,
   input  logic                            req_i,
   output logic                            gnt_o,
   input  logic [AW-1:0]                   add_i,
   input  logic                            wen_i,
   input  logic [DW/8-1:0]                 be_i,
   input  logic [DW-1:0]                   data_i,
   input  logic [UW-1:0]                   user_i,
   output logic [DW-1:0]                   r_data_o,
   output logic [UW-1:0]                   r_user_o,
   output logic                            r_valid_o,
   input  logic                            r_ready_i,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] occupancy_o
);

   localparam int c_bw   = DW / 8;
   localparam int c_woff = $clog2(c_bw);
   localparam int c_iw   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_ow   = $clog2(FIFO_DEPTH + 1);
   localparam int c_pw   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [DW-1:0]   r_mem   [DEPTH];
   logic [DW-1:0]   r_fdata [FIFO_DEPTH];
   logic [UW-1:0]   r_fuser [FIFO_DEPTH];
   logic [c_pw-1:0] r_wptr;
   logic [c_pw-1:0] r_rptr;
   logic [c_ow-1:0] r_fcnt;
   logic [c_ow-1:0] r_occ;

   logic [c_iw-1:0] w_idx;
   logic [DW-1:0]   w_rdata;
   logic            w_hs_rd;
   logic            w_hs_wr;
   logic            w_push;
   logic [DW-1:0]   w_push_data;
   logic [UW-1:0]   w_push_user;
   logic            w_pop;

   function automatic logic [c_pw-1:0] ptr_inc(input logic [c_pw-1:0] p);
      return (p == c_pw'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Reads consume a credit at grant time; a same-cycle pop is deliberately not credited.
   assign gnt_o   = req_i & ~stall_i & ~rst_i & ~clear_i &
                    (~wen_i | (r_occ < c_ow'(FIFO_DEPTH)));
   assign w_hs_rd = gnt_o & wen_i;
   assign w_hs_wr = gnt_o & ~wen_i;
   assign w_idx   = add_i[c_woff +: c_iw];
   assign w_rdata = r_mem[w_idx];

   always_ff @(posedge clk_i) begin
      if (w_hs_wr) begin
         for (int k = 0; k < c_bw; k++) begin
            if (be_i[k]) r_mem[w_idx][8*k +: 8] <= data_i[8*k +: 8];
         end
      end
   end

   generate
      if (LAT == 1) begin : g_lat1
         assign w_push      = w_hs_rd;
         assign w_push_data = w_rdata;
         assign w_push_user = user_i;
      end else begin : g_pipe
         logic [LAT-2:0] r_pvld;
         logic [DW-1:0]  r_pdata [LAT-1];
         logic [UW-1:0]  r_puser [LAT-1];

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               r_pvld <= '0;
            end else if (clear_i) begin
               r_pvld <= '0;
            end else begin
               r_pvld[0] <= w_hs_rd;
               for (int s = 1; s < LAT - 1; s++) r_pvld[s] <= r_pvld[s-1];
            end
         end

         always_ff @(posedge clk_i) begin
            r_pdata[0] <= w_rdata;
            r_puser[0] <= user_i;
            for (int s = 1; s < LAT - 1; s++) begin
               r_pdata[s] <= r_pdata[s-1];
               r_puser[s] <= r_puser[s-1];
            end
         end

         assign w_push      = r_pvld[LAT-2];
         assign w_push_data = r_pdata[LAT-2];
         assign w_push_user = r_puser[LAT-2];
      end
   endgenerate

   assign r_valid_o   = (r_fcnt != '0);
   assign w_pop       = r_valid_o & r_ready_i;
   assign r_data_o    = r_valid_o ? r_fdata[r_rptr] : '0;
   assign r_user_o    = r_valid_o ? r_fuser[r_rptr] : '0;
   assign occupancy_o = r_occ;

   always_ff @(posedge clk_i) begin
      if (w_push && !clear_i) begin
         r_fdata[r_wptr] <= w_push_data;
         r_fuser[r_wptr] <= w_push_user;
      end
   end

   // r_fcnt tracks FIFO entries only; r_occ also covers reads still in the pipeline.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_fcnt <= '0;
         r_occ  <= '0;
      end else if (clear_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_fcnt <= '0;
         r_occ  <= '0;
      end else begin
         if (w_push) r_wptr <= ptr_inc(r_wptr);
         if (w_pop)  r_rptr <= ptr_inc(r_rptr);
         case ({w_push, w_pop})
            2'b10:   r_fcnt <= r_fcnt + 1'b1;
            2'b01:   r_fcnt <= r_fcnt - 1'b1;
            default: ;
         endcase
         case ({w_hs_rd, w_pop})
            2'b10:   r_occ <= r_occ + 1'b1;
            2'b01:   r_occ <= r_occ - 1'b1;
            default: ;
         endcase
      end
   end

   a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
      !(w_push && (r_fcnt == c_ow'(FIFO_DEPTH))));
   a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
      !(w_pop && (r_fcnt == '0)));
   a_hold_stable:  assert property (@(posedge clk_i) disable iff (rst_i)
      (r_valid_o && !r_ready_i && !clear_i) |=> $stable(r_data_o));

endmodule
`default_nettype wire
